// File: rtl/esdi_pkg.sv
// ---------------------------------------------------------------------------
// esdi_pkg
//   Shared definitions for the ESDI serial command channel:
//   - esdi_state_e  : command-initiator FSM states
//   - ESDI_FRAME_BITS / ESDI_DATA_BITS : frame geometry (16 data + 1 parity)
//   - esdi_odd_parity : parity bit that makes the ones count of a frame odd.
//     The drive-side receiver uses the same function.
// ---------------------------------------------------------------------------
package esdi_pkg;

    localparam int ESDI_FRAME_BITS = 17;
    localparam int ESDI_DATA_BITS  = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        C_SETUP = 3'd1,
        C_REQ   = 3'd2,
        C_REL   = 3'd3,
        R_REQ   = 3'd4,
        R_REL   = 3'd5,
        CC_WAIT = 3'd6,
        DONE    = 3'd7
    } esdi_state_e;

    // Parity bit appended after the data bits so that the 17-bit frame
    // carries an odd number of ones.
    function automatic logic esdi_odd_parity(input logic [ESDI_DATA_BITS-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/esdi_sync2.sv
// ---------------------------------------------------------------------------
// esdi_sync2
//   Parameterized-width two-flop synchronizer for asynchronous drive inputs.
//   Ports:
//     clk    in   system clock
//     rst    in   synchronous active-high reset (clears both stages)
//     d_i    in   [WIDTH] asynchronous inputs
//     q_o    out  [WIDTH] synchronized outputs, 2 clocks of latency
// ---------------------------------------------------------------------------
module esdi_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/esdi_cmd_initiator.sv
// ---------------------------------------------------------------------------
// esdi_cmd_initiator
//   Host-side ESDI serial command engine. Shifts a 16-bit command plus an
//   odd-parity bit to the drive with the TRANSFER REQ / TRANSFER ACK
//   handshake, optionally reads back a 17-bit status/config frame, waits for
//   COMMAND COMPLETE and reports the result with a one-cycle rsp_valid.
//
//   Handshake on the host side: a command is accepted on a clock where
//   cmd_valid && cmd_ready; cmd_ready is high only while the FSM is IDLE and
//   the command fields are sampled on that same clock. rsp_valid is a
//   one-cycle pulse with no back-pressure; rsp_word / rsp_parity_err /
//   rsp_timeout stay valid from that pulse until the next accept.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     cmd_valid/cmd_ready      command offer / engine idle
//     cmd_word[15:0]           command, sent MSB first
//     cmd_resp                 read a status word after the command
//     esdi_transfer_req        registered request to the drive
//     esdi_command_data        serial command bit (0 outside command phase)
//     esdi_transfer_ack        drive acknowledge (async)
//     esdi_confstat_data       serial response bit (async)
//     esdi_command_complete    drive command complete (async)
//     rsp_valid                one-cycle completion pulse
//     rsp_word[15:0]           received word (0 when no response read)
//     rsp_parity_err           received frame had an even ones count
//     rsp_timeout              a wait phase exceeded TIMEOUT_CYCLES
//     dbg_state[2:0]           current FSM state (esdi_state_e encoding)
// ---------------------------------------------------------------------------
module esdi_cmd_initiator
    import esdi_pkg::*;
#(
    parameter int SETUP_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_word,
    input  logic        cmd_resp,
    output logic        esdi_transfer_req,
    output logic        esdi_command_data,
    input  logic        esdi_transfer_ack,
    input  logic        esdi_confstat_data,
    input  logic        esdi_command_complete,
    output logic        rsp_valid,
    output logic [15:0] rsp_word,
    output logic        rsp_parity_err,
    output logic        rsp_timeout,
    output logic [2:0]  dbg_state
);

    localparam logic [TO_W-1:0] TO_LIMIT   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] SETUP_LAST = TO_W'(SETUP_CYCLES - 1);
    localparam logic [4:0]      LAST_BIT   = 5'(ESDI_FRAME_BITS - 1);

    // ------------------------------------------------------------------
    // Input synchronization: bit 0 = ack, bit 1 = confstat, bit 2 = cc
    // ------------------------------------------------------------------
    logic [2:0] sync_out;
    logic       ack_s;
    logic       conf_s;
    logic       cc_s;

    esdi_sync2 #(.WIDTH(3)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i ({esdi_command_complete, esdi_confstat_data, esdi_transfer_ack}),
        .q_o (sync_out)
    );

    assign ack_s  = sync_out[0];
    assign conf_s = sync_out[1];
    assign cc_s   = sync_out[2];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    esdi_state_e                      state_q;
    logic [TO_W-1:0]                  timer_q;
    logic [4:0]                       bit_cnt_q;
    logic [ESDI_FRAME_BITS-1:0]       frame_q;
    logic                             resp_q;
    logic [ESDI_FRAME_BITS-1:0]       shreg_q;
    logic                             req_q;
    logic                             data_q;
    logic                             ready_q;
    logic                             rsp_valid_q;
    logic [ESDI_DATA_BITS-1:0]        rsp_word_q;
    logic                             perr_q;
    logic                             tout_q;

    // Frame bit that follows the one currently on the wire. Only consumed
    // while bit_cnt_q < 16, so the wrap at bit_cnt_q = 16 is harmless.
    logic [4:0] next_bit_idx;
    assign next_bit_idx = 5'd15 - bit_cnt_q;

    // Every handshake/complete wait shares one timeout limit.
    logic wait_state;
    logic timeout_hit;
    logic parity_bad;

    always_comb begin
        wait_state = 1'b0;
        case (state_q)
            C_REQ, C_REL, R_REQ, R_REL, CC_WAIT: wait_state = 1'b1;
            default:                             wait_state = 1'b0;
        endcase
        timeout_hit = wait_state && (timer_q == TO_LIMIT);
        // An even ones count over the 17 received bits is a parity error.
        parity_bad  = resp_q && !(^shreg_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            resp_q      <= 1'b0;
            shreg_q     <= '0;
            req_q       <= 1'b0;
            data_q      <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_word_q  <= '0;
            perr_q      <= 1'b0;
            tout_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            // Timer free-runs; every state change below overrides it with 0.
            timer_q     <= timer_q + TO_W'(1);

            if (timeout_hit) begin
                // Abandon the transaction and report whatever was received.
                state_q     <= DONE;
                timer_q     <= '0;
                req_q       <= 1'b0;
                data_q      <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_word_q  <= shreg_q[ESDI_FRAME_BITS-1:1];
                perr_q      <= parity_bad;
                tout_q      <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        timer_q <= '0;
                        data_q  <= 1'b0;
                        if (cmd_valid && ready_q) begin
                            frame_q    <= {cmd_word, esdi_odd_parity(cmd_word)};
                            resp_q     <= cmd_resp;
                            bit_cnt_q  <= '0;
                            shreg_q    <= '0;
                            ready_q    <= 1'b0;
                            // First bit on the wire is frame[16] = cmd_word[15].
                            data_q     <= cmd_word[15];
                            rsp_word_q <= '0;
                            perr_q     <= 1'b0;
                            tout_q     <= 1'b0;
                            state_q    <= C_SETUP;
                        end
                    end

                    C_SETUP: begin
                        // Data has been on the wire since entering this state.
                        if (timer_q == SETUP_LAST) begin
                            req_q   <= 1'b1;
                            timer_q <= '0;
                            state_q <= C_REQ;
                        end
                    end

                    C_REQ: begin
                        if (ack_s) begin
                            req_q   <= 1'b0;
                            timer_q <= '0;
                            state_q <= C_REL;
                        end
                    end

                    C_REL: begin
                        // Data stays put until the drive has released ack.
                        if (!ack_s) begin
                            timer_q <= '0;
                            if (bit_cnt_q == LAST_BIT) begin
                                data_q    <= 1'b0;
                                bit_cnt_q <= '0;
                                if (resp_q) begin
                                    req_q   <= 1'b1;
                                    state_q <= R_REQ;
                                end else begin
                                    state_q <= CC_WAIT;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                                data_q    <= frame_q[next_bit_idx];
                                state_q   <= C_SETUP;
                            end
                        end
                    end

                    R_REQ: begin
                        if (ack_s) begin
                            shreg_q <= {shreg_q[ESDI_FRAME_BITS-2:0], conf_s};
                            req_q   <= 1'b0;
                            timer_q <= '0;
                            state_q <= R_REL;
                        end
                    end

                    R_REL: begin
                        if (!ack_s) begin
                            timer_q <= '0;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= CC_WAIT;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                                req_q     <= 1'b1;
                                state_q   <= R_REQ;
                            end
                        end
                    end

                    CC_WAIT: begin
                        if (cc_s) begin
                            // Full frame: data bits sit above the parity bit.
                            timer_q     <= '0;
                            rsp_valid_q <= 1'b1;
                            rsp_word_q  <= shreg_q[ESDI_FRAME_BITS-1:1];
                            perr_q      <= parity_bad;
                            tout_q      <= 1'b0;
                            state_q     <= DONE;
                        end
                    end

                    DONE: begin
                        // cmd_valid seen here waits for the IDLE cycle.
                        timer_q <= '0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end

                    default: begin
                        req_q   <= 1'b0;
                        data_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign cmd_ready         = ready_q;
    assign esdi_transfer_req = req_q;
    assign esdi_command_data = data_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_word          = rsp_word_q;
    assign rsp_parity_err    = perr_q;
    assign rsp_timeout       = tout_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_esdi_cmd_initiator.sv
// ---------------------------------------------------------------------------
// tb_esdi_cmd_initiator
//   Directed bench for esdi_cmd_initiator with a simple drive model that
//   answers every request after a fixed delay, records the command bits it
//   sees at each request edge and serves a programmed 17-bit response frame.
// ---------------------------------------------------------------------------
module tb_esdi_cmd_initiator;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_word = 16'h0000;
    logic        cmd_resp = 1'b0;
    logic        ack = 1'b0;
    logic        conf = 1'b0;
    logic        cc = 1'b1;

    logic        cmd_ready;
    logic        req;
    logic        cdata;
    logic        rsp_valid;
    logic [15:0] rsp_word;
    logic        perr;
    logic        tout;
    logic [2:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;

    // drive model controls
    int          ack_delay = 5;
    int          stall_bit = -1;
    logic [16:0] resp_frame = 17'h0;

    // drive model observations
    int          pulses = 0;
    logic [16:0] cmd_cap = 17'h0;
    logic [16:0] rsp_sh = 17'h0;
    int          bfm_idx = 0;
    int          bfm_cnt = 0;

    esdi_cmd_initiator #(
        .SETUP_CYCLES   (4),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (16)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_word              (cmd_word),
        .cmd_resp              (cmd_resp),
        .esdi_transfer_req     (req),
        .esdi_command_data     (cdata),
        .esdi_transfer_ack     (ack),
        .esdi_confstat_data    (conf),
        .esdi_command_complete (cc),
        .rsp_valid             (rsp_valid),
        .rsp_word              (rsp_word),
        .rsp_parity_err        (perr),
        .rsp_timeout           (tout),
        .dbg_state             (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- drive model ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst || cmd_ready) begin
                ack     = 1'b0;
                bfm_idx = 0;
                bfm_cnt = 0;
            end else if (req && !ack) begin
                if (bfm_cnt == 0) begin
                    if (bfm_idx == 0) cmd_cap = 17'h0;
                    if (bfm_idx < 17) begin
                        cmd_cap = {cmd_cap[15:0], cdata};
                    end else begin
                        if (bfm_idx == 17) rsp_sh = resp_frame;
                        conf   = rsp_sh[16];
                        rsp_sh = {rsp_sh[15:0], 1'b0};
                    end
                    bfm_idx = bfm_idx + 1;
                    pulses  = bfm_idx;
                end
                bfm_cnt = bfm_cnt + 1;
                if (bfm_cnt >= ack_delay && (bfm_idx - 1) != stall_bit) begin
                    ack     = 1'b1;
                    bfm_cnt = 0;
                end
            end else if (!req && ack) begin
                bfm_cnt = bfm_cnt + 1;
                if (bfm_cnt >= ack_delay) begin
                    ack     = 1'b0;
                    bfm_cnt = 0;
                end
            end else begin
                bfm_cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] w, input logic r);
        int n;
        n = 0;
        while (!cmd_ready && n < 4000) begin
            tick();
            n++;
        end
        cmd_word  = w;
        cmd_resp  = r;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (4) tick();
        vectors++;
        if (req !== 1'b0 || cdata !== 1'b0) begin
            $display("FAIL reset_pins: req=%b data=%b expected 0 0", req, cdata);
            miscompares++;
        end
        vectors++;
        if (cmd_ready !== 1'b1 || dbg_state !== 3'd0) begin
            $display("FAIL reset_idle: ready=%b state=%0d expected 1 0", cmd_ready, dbg_state);
            miscompares++;
        end
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_word !== 16'h0 || perr !== 1'b0 || tout !== 1'b0) begin
            $display("FAIL reset_rsp: valid=%b word=%h perr=%b tout=%b expected all 0",
                     rsp_valid, rsp_word, perr, tout);
            miscompares++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cmd_no_resp(input logic [15:0] w, input logic [16:0] exp_frame);
        bit got;
        send_cmd(w, 1'b0);
        wait_rsp(got);
        vectors++;
        if (!got) begin
            $display("FAIL noresp_done: rsp_valid not seen for cmd %h", w);
            miscompares++;
        end
        vectors++;
        if (pulses !== 17 || cmd_cap !== exp_frame) begin
            $display("FAIL noresp_serial: pulses=%0d frame=%h expected 17 %h", pulses, cmd_cap, exp_frame);
            miscompares++;
        end
        vectors++;
        if (rsp_word !== 16'h0 || perr !== 1'b0 || tout !== 1'b0) begin
            $display("FAIL noresp_rsp: word=%h perr=%b tout=%b expected 0000 0 0", rsp_word, perr, tout);
            miscompares++;
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            $display("FAIL noresp_pulse: valid=%b ready=%b expected 0 1", rsp_valid, cmd_ready);
            miscompares++;
        end
    endtask

    task automatic test_cmd_resp(input logic [15:0] w, input logic [16:0] exp_frame,
                                 input logic [16:0] rframe, input logic [15:0] exp_word,
                                 input logic exp_perr);
        bit got;
        resp_frame = rframe;
        send_cmd(w, 1'b1);
        wait_rsp(got);
        vectors++;
        if (!got) begin
            $display("FAIL resp_done: rsp_valid not seen for cmd %h", w);
            miscompares++;
        end
        vectors++;
        if (pulses !== 34 || cmd_cap !== exp_frame) begin
            $display("FAIL resp_serial: pulses=%0d frame=%h expected 34 %h", pulses, cmd_cap, exp_frame);
            miscompares++;
        end
        vectors++;
        if (rsp_word !== exp_word || perr !== exp_perr || tout !== 1'b0) begin
            $display("FAIL resp_rsp: word=%h perr=%b tout=%b expected %h %b 0",
                     rsp_word, perr, tout, exp_word, exp_perr);
            miscompares++;
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_word !== exp_word || perr !== exp_perr) begin
            $display("FAIL resp_hold: valid=%b word=%h perr=%b expected 0 %h %b",
                     rsp_valid, rsp_word, perr, exp_word, exp_perr);
            miscompares++;
        end
    endtask

    task automatic test_timeout();
        int n;
        stall_bit = 3;
        send_cmd(16'hFFFF, 1'b0);
        n = 0;
        while (!(pulses == 4 && req) && n < 2000) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 2000) begin
            $display("FAIL timeout_reach: bit 3 request not seen, pulses=%0d", pulses);
            miscompares++;
        end
        n = 0;
        while (req && n < 300) begin
            tick();
            n++;
        end
        vectors++;
        if (n < 95 || n > 110) begin
            $display("FAIL timeout_len: req held %0d clocks expected about 100", n);
            miscompares++;
        end
        vectors++;
        if (rsp_valid !== 1'b1 || tout !== 1'b1 || rsp_word !== 16'h0 || perr !== 1'b0) begin
            $display("FAIL timeout_rsp: valid=%b tout=%b word=%h perr=%b expected 1 1 0000 0",
                     rsp_valid, tout, rsp_word, perr);
            miscompares++;
        end
        tick();
        vectors++;
        if (cmd_ready !== 1'b1 || req !== 1'b0) begin
            $display("FAIL timeout_idle: ready=%b req=%b expected 1 0", cmd_ready, req);
            miscompares++;
        end
        stall_bit = -1;
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        int n;
        send_cmd(16'h5555, 1'b0);
        n = 0;
        while (!(pulses == 9 && req) && n < 2000) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 2000) begin
            $display("FAIL rstmid_reach: bit 8 request not seen, pulses=%0d", pulses);
            miscompares++;
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (req !== 1'b0 || cmd_ready !== 1'b1) begin
            $display("FAIL rstmid_drop: req=%b ready=%b expected 0 1", req, cmd_ready);
            miscompares++;
        end
        rst = 1'b0;
        repeat (8) tick();
        // clean transaction after the reset: 0x00FF -> parity 1, drive returns 0xBEEF
        test_cmd_resp(16'h00FF, {16'h00FF, 1'b1}, {16'hBEEF, 1'b0}, 16'hBEEF, 1'b0);
    endtask

    task automatic test_cc_delay();
        int  n;
        bit  early;
        bit  got;
        cc        = 1'b0;
        cmd_word  = 16'h1111;
        cmd_resp  = 1'b0;
        cmd_valid = 1'b1;
        tick();
        n = 0;
        while (pulses != 17 && n < 2000) begin tick(); n++; end
        while (!ack && n < 2000) begin tick(); n++; end
        while (ack && n < 2000) begin tick(); n++; end
        vectors++;
        if (n >= 2000) begin
            $display("FAIL cc_reach: last bit not completed, pulses=%0d", pulses);
            miscompares++;
        end
        early = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rsp_valid || cmd_ready) early = 1'b1;
        end
        vectors++;
        if (early) begin
            $display("FAIL cc_early: rsp_valid or cmd_ready seen while complete low, got 1 expected 0");
            miscompares++;
        end
        cc = 1'b1;
        n  = 0;
        while (n < 20) begin
            tick();
            n++;
            if (rsp_valid) break;
        end
        vectors++;
        if (n !== 3) begin
            $display("FAIL cc_latency: rsp_valid after %0d clocks expected 3", n);
            miscompares++;
        end
        vectors++;
        if (cmd_ready !== 1'b0 || cmd_cap !== 17'h02223 || rsp_word !== 16'h0) begin
            $display("FAIL cc_done: ready=%b frame=%h word=%h expected 0 02223 0000",
                     cmd_ready, cmd_cap, rsp_word);
            miscompares++;
        end
        tick();
        vectors++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            $display("FAIL cc_idle: ready=%b valid=%b expected 1 0", cmd_ready, rsp_valid);
            miscompares++;
        end
        tick();
        vectors++;
        if (cmd_ready !== 1'b0) begin
            $display("FAIL cc_accept: ready=%b expected 0 after accept in IDLE", cmd_ready);
            miscompares++;
        end
        cmd_valid = 1'b0;
        wait_rsp(got);
        vectors++;
        if (!got || tout !== 1'b0) begin
            $display("FAIL cc_second: got=%b tout=%b expected 1 0", got, tout);
            miscompares++;
        end
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        // 0x0000: zero ones -> parity 1
        test_cmd_no_resp(16'h0000, {16'h0000, 1'b1});
        // 0x0007: three ones -> parity 0
        test_cmd_no_resp(16'h0007, {16'h0007, 1'b0});
        // 0xA5C3: eight ones -> parity 1; 0x1234 has five ones, parity 0 is correct
        test_cmd_resp(16'hA5C3, {16'hA5C3, 1'b1}, {16'h1234, 1'b0}, 16'h1234, 1'b0);
        // bad parity from the drive
        test_cmd_resp(16'h8001, {16'h8001, 1'b1}, {16'h1234, 1'b1}, 16'h1234, 1'b1);
        test_timeout();
        test_reset_mid();
        test_cc_delay();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
